// File: rtl/serial_subtractor_n.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_n
//  Description : Bit-serial WIDTH-bit subtractor computing
//                diff = a - b - borrow_in, one bit per clock, LSB first.
//                It uses a single full-subtractor cell and a borrow flip-flop,
//                with a start/done handshake.
//                Optional macro SUB_OVERFLOW_FLAG_EN adds a signed-overflow
//                output (o_overflow).
//  Revision    : 1.0  initial release
// ============================================================================
module serial_subtractor_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_borrow_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow_out,
    output logic             o_zero
`ifdef SUB_OVERFLOW_FLAG_EN
    ,
    output logic             o_overflow
`endif
);

    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;

    // r_a doubles as the result shift register: each computed bit enters at
    // the MSB as the consumed minuend bit leaves at the LSB.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_br;
    logic [CW-1:0]    r_count;

    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic [WIDTH-1:0] w_diff_final;

`ifdef SUB_OVERFLOW_FLAG_EN
    logic             r_a_msb;
    logic             r_b_msb;
`endif

    // Full-subtractor cell on the current LSBs plus the stored borrow
    always_comb begin
        w_d          = r_a[0] ^ r_b[0] ^ r_br;
        w_br_next    = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
        w_last       = (r_state == S_RUN) && (r_count == c_LAST);
        w_diff_final = {w_d, r_a[WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic, start acceptance and handshake outputs
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        o_busy       = (r_state == S_RUN);
        o_done       = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (r_count == c_LAST) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                // Back-to-back: a start in the done cycle goes straight to RUN
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial shifting and result publication
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_br         <= 1'b0;
            r_count      <= '0;
            o_diff       <= '0;
            o_borrow_out <= 1'b0;
            o_zero       <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            o_overflow   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_br    <= i_borrow_in;
            r_count <= '0;
`ifdef SUB_OVERFLOW_FLAG_EN
            // The operand MSBs are shifted away, so keep copies for overflow
            r_a_msb <= i_a[WIDTH-1];
            r_b_msb <= i_b[WIDTH-1];
`endif
        end else if (r_state == S_RUN) begin
            r_a     <= w_diff_final;
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_br    <= w_br_next;
            r_count <= r_count + CW'(1);
            // Outputs change only on the final bit, so partial results stay hidden
            if (w_last) begin
                o_diff       <= w_diff_final;
                o_borrow_out <= w_br_next;
                o_zero       <= (w_diff_final == '0);
`ifdef SUB_OVERFLOW_FLAG_EN
                o_overflow   <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor_n
//  Description : Self-checking bench for serial_subtractor_n (WIDTH=8),
//                using directed and random operations against an arithmetic
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_subtractor_n;

    localparam int W = 8;

    logic         clk         = 1'b0;
    logic         reset_n     = 1'b0;
    logic         i_start     = 1'b0;
    logic [W-1:0] i_a         = '0;
    logic [W-1:0] i_b         = '0;
    logic         i_borrow_in = 1'b0;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_diff;
    logic         o_borrow_out;
    logic         o_zero;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic         o_overflow;
`endif

    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [W-1:0] held_diff = '0;

    serial_subtractor_n #(.WIDTH(W)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_start      (i_start),
        .i_a          (i_a),
        .i_b          (i_b),
        .i_borrow_in  (i_borrow_in),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_diff       (o_diff),
        .o_borrow_out (o_borrow_out),
        .o_zero       (o_zero)
`ifdef SUB_OVERFLOW_FLAG_EN
        ,
        .o_overflow   (o_overflow)
`endif
    );

    always #5 clk = ~clk;

    // Reference: {borrow, diff} of a - b - bin using plain integer arithmetic
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        int r;
        r = int'(a) - int'(b) - int'(bin);
        if (r < 0) return {1'b1, W'(r + (1 << W))};
        return {1'b0, W'(r)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start high for one edge, then scramble the inputs
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        i_a         = a;
        i_b         = b;
        i_borrow_in = bin;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
        i_a         = W'($urandom);
        i_b         = W'($urandom);
        i_borrow_in = 1'($urandom);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({o_busy, o_done, o_borrow_out, o_zero} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/borrow/zero=%b expected 0000",
                     {o_busy, o_done, o_borrow_out, o_zero});
        end
        n_cmp++;
        if (o_diff !== '0) begin
            n_fail++;
            $display("FAIL reset_diff: got %h expected 00", o_diff);
        end
`ifdef SUB_OVERFLOW_FLAG_EN
        n_cmp++;
        if (o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_overflow: got %b expected 0", o_overflow);
        end
`endif
        reset_n = 1'b1;
        tick();
        held_diff = '0;
    endtask

    // Directed cases followed by random ones; checks timing and results
    task automatic test_arith();
        logic [W-1:0] ta[6] = '{8'h35, 8'h00, 8'h10, 8'h42, 8'h80, 8'h05};
        logic [W-1:0] tb[6] = '{8'h12, 8'h01, 8'h10, 8'h42, 8'h01, 8'h03};
        logic         tc[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [W-1:0] a, b;
        logic         bin;
        logic [W:0]   exp;
        for (int n = 0; n < 36; n++) begin
            if (n < 6) begin
                a = ta[n]; b = tb[n]; bin = tc[n];
            end else begin
                a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            end
            exp = ref_sub(a, b, bin);
            launch(a, b, bin);
            n_cmp++;
            if (o_busy !== 1'b1 || o_done !== 1'b0) begin
                n_fail++;
                $display("FAIL arith_start op%0d: busy=%b done=%b expected busy=1 done=0",
                         n, o_busy, o_done);
            end
            for (int k = 1; k <= W; k++) begin
                tick();
                if (k < W) begin
                    n_cmp++;
                    if (o_busy !== 1'b1 || o_done !== 1'b0 || o_diff !== held_diff) begin
                        n_fail++;
                        $display("FAIL arith_run op%0d cyc%0d: busy=%b done=%b diff=%h expected 1 0 %h",
                                 n, k, o_busy, o_done, o_diff, held_diff);
                    end
                end
            end
            n_cmp++;
            if (o_busy !== 1'b0 || o_done !== 1'b1) begin
                n_fail++;
                $display("FAIL arith_done op%0d: busy=%b done=%b expected busy=0 done=1",
                         n, o_busy, o_done);
            end
            n_cmp++;
            if (o_diff !== exp[W-1:0] || o_borrow_out !== exp[W]
                || o_zero !== (exp[W-1:0] == '0)) begin
                n_fail++;
                $display("FAIL arith_result op%0d a=%h b=%h bin=%b: diff=%h borrow=%b zero=%b expected %h %b %b",
                         n, a, b, bin, o_diff, o_borrow_out, o_zero,
                         exp[W-1:0], exp[W], (exp[W-1:0] == '0));
            end
`ifdef SUB_OVERFLOW_FLAG_EN
            n_cmp++;
            if (o_overflow !== ((a[W-1] ^ b[W-1]) & (a[W-1] ^ exp[W-1]))) begin
                n_fail++;
                $display("FAIL arith_overflow op%0d a=%h b=%h: got %b expected %b",
                         n, a, b, o_overflow, (a[W-1] ^ b[W-1]) & (a[W-1] ^ exp[W-1]));
            end
`endif
            held_diff = exp[W-1:0];
            tick();
            n_cmp++;
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_diff !== held_diff) begin
                n_fail++;
                $display("FAIL arith_hold op%0d: done=%b busy=%b diff=%h expected 0 0 %h",
                         n, o_done, o_busy, o_diff, held_diff);
            end
        end
    endtask

    task automatic test_back_to_back();
        launch(8'h42, 8'h42, 1'b0);
        for (int k = 1; k <= W; k++) tick();
        n_cmp++;
        if (o_done !== 1'b1 || o_diff !== 8'h00 || o_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b diff=%h zero=%b expected 1 00 1",
                     o_done, o_diff, o_zero);
        end
        held_diff = 8'h00;
        launch(8'h05, 8'h03, 1'b0);
        n_cmp++;
        if (o_busy !== 1'b1 || o_done !== 1'b0 || o_diff !== 8'h00) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b diff=%h expected 1 0 00",
                     o_busy, o_done, o_diff);
        end
        for (int k = 1; k <= W; k++) tick();
        n_cmp++;
        if (o_done !== 1'b1 || o_diff !== 8'h02 || o_borrow_out !== 1'b0 || o_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: done=%b diff=%h borrow=%b zero=%b expected 1 02 0 0",
                     o_done, o_diff, o_borrow_out, o_zero);
        end
        tick();
        held_diff = 8'h02;
    endtask

    task automatic test_start_ignored();
        int n_done = 0;
        launch(8'h35, 8'h12, 1'b0);
        for (int k = 1; k <= W + 3; k++) begin
            if (k == 2) begin
                i_start = 1'b1; i_a = 8'hFF; i_b = 8'h00; i_borrow_in = 1'b1;
            end
            if (k == 5) i_start = 1'b0;
            tick();
            if (o_done === 1'b1) n_done++;
            n_cmp++;
            if (o_done !== (k == W)) begin
                n_fail++;
                $display("FAIL ignore_timing cyc%0d: done=%b expected %b", k, o_done, (k == W));
            end
        end
        n_cmp++;
        if (n_done != 1 || o_diff !== 8'h23 || o_borrow_out !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_result: dones=%0d diff=%h borrow=%b expected 1 23 0",
                     n_done, o_diff, o_borrow_out);
        end
        held_diff = 8'h23;
    endtask

    task automatic test_reset_mid_run();
        int n_done = 0;
        launch(8'h35, 8'h12, 1'b0);
        for (int k = 1; k <= 3; k++) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_cmp++;
        if ({o_busy, o_done, o_borrow_out, o_zero} !== 4'b0000 || o_diff !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_state: busy/done/borrow/zero=%b diff=%h expected 0000 00",
                     {o_busy, o_done, o_borrow_out, o_zero}, o_diff);
        end
        for (int k = 0; k < W + 2; k++) begin
            tick();
            if (o_done === 1'b1 || o_busy === 1'b1) n_done++;
        end
        n_cmp++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: active cycles=%0d expected 0", n_done);
        end
        launch(8'h05, 8'h03, 1'b0);
        for (int k = 1; k <= W; k++) tick();
        n_cmp++;
        if (o_done !== 1'b1 || o_diff !== 8'h02 || o_borrow_out !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_recover: done=%b diff=%h borrow=%b expected 1 02 0",
                     o_done, o_diff, o_borrow_out);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
